data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_pkg.sv | 41 ++++
 rtl/data_mem_lane.sv | 39 +++
 rtl/data_mem_ctrl.sv | 138 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared encodings and defaults for the data memory controller.
// Build option: DATA_MEM_MISALIGN_CHECK_EN enables misalignment/illegal-mode error responses.
package data_mem_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 16;
   localparam int unsigned DEF_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      MODE_B = 2'b00,
      MODE_H = 2'b01,
      MODE_W = 2'b10,
      MODE_X = 2'b11
   } mode_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WAIT = 3'd2,
      ST_WR   = 3'd3,
      ST_RESP = 3'd4
   } state_t;

   typedef struct packed {
      logic  we;
      mode_t mode;
      logic  sgn;
   } req_ctl_t;

   // True when the low address bits do not suit the access size, or the mode is illegal.
   function automatic logic is_misaligned(input mode_t m, input logic [1:0] off);
      logic r;
      case (m)
         MODE_B:  r = 1'b0;
         MODE_H:  r = off[0];
         MODE_W:  r = (off != 2'b00);
         default: r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/data_mem_lane.sv
// Little-endian lane extract/extend for loads and lane merge for read-modify-write stores.
module data_mem_lane import data_mem_pkg::*; #(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] i_word,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [1:0]            i_off,
   input  mode_t                 i_mode,
   input  logic                  i_sgn,
   output logic [DATA_WIDTH-1:0] o_load_c,
   output logic [DATA_WIDTH-1:0] o_merged_c
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_word[{i_off, 3'b000} +: 8];
   assign w_half = i_word[{i_off[1], 4'b0000} +: 16];

   always_comb begin
      o_load_c   = i_word;
      o_merged_c = i_word;
      case (i_mode)
         MODE_B: begin
            o_load_c = {{(DATA_WIDTH-8){i_sgn & w_byte[7]}}, w_byte};
            o_merged_c[{i_off, 3'b000} +: 8] = i_wdata[7:0];
         end
         MODE_H: begin
            o_load_c = {{(DATA_WIDTH-16){i_sgn & w_half[15]}}, w_half};
            o_merged_c[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
         end
         default: begin
            o_load_c   = i_word;
            o_merged_c = i_wdata;
         end
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte/half/word load-store controller in front of a synchronous data RAM.
// Build option: DATA_MEM_MISALIGN_CHECK_EN reports misaligned/illegal accesses instead of masking them.
module data_mem_ctrl import data_mem_pkg::*; #(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_mode,
   input  logic                  req_signed,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  ram_ena,
   output logic                  ram_wr_flag,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   state_t                r_state;
   req_ctl_t              r_ctl;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_ram_wdata;
   logic [DATA_WIDTH-1:0] r_resp_rdata;
   logic                  r_resp_valid;
   logic                  r_resp_err;

   mode_t                 w_mode_eff;
   logic [ADDR_WIDTH-1:0] w_addr_eff;
   logic                  w_err;
   logic [DATA_WIDTH-1:0] w_load;
   logic [DATA_WIDTH-1:0] w_merged;

`ifdef DATA_MEM_MISALIGN_CHECK_EN
   // Bad accesses are flagged at accept and never reach the RAM.
   always_comb begin
      w_mode_eff = mode_t'(req_mode);
      w_addr_eff = req_addr;
      w_err      = is_misaligned(mode_t'(req_mode), req_addr[1:0]);
   end
`else
   // Illegal mode behaves as word; low address bits are forced to the access size.
   always_comb begin
      w_mode_eff = (req_mode == MODE_X) ? MODE_W : mode_t'(req_mode);
      w_addr_eff = req_addr;
      w_err      = 1'b0;
      case (w_mode_eff)
         MODE_H:  w_addr_eff[0]   = 1'b0;
         MODE_W:  w_addr_eff[1:0] = 2'b00;
         default: ;
      endcase
   end
`endif

   data_mem_lane #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_lane (
      .i_word     (ram_rdata),
      .i_wdata    (r_wdata),
      .i_off      (r_addr[1:0]),
      .i_mode     (r_ctl.mode),
      .i_sgn      (r_ctl.sgn),
      .o_load_c   (w_load),
      .o_merged_c (w_merged)
   );

   // Sequencer: response fields are loaded on the edge entering RESP and cleared otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_ctl        <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_ram_wdata  <= '0;
         r_resp_rdata <= '0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
      end else begin
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_ctl   <= '{we: req_we, mode: w_mode_eff, sgn: req_signed};
                  r_addr  <= w_addr_eff;
                  r_wdata <= req_wdata;
                  if (w_err) begin
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                     r_state      <= ST_RESP;
                  end else if (req_we && (w_mode_eff == MODE_W)) begin
                     r_ram_wdata <= req_wdata;
                     r_state     <= ST_WR;
                  end else begin
                     r_state <= ST_RD;
                  end
               end
            end
            ST_RD:   r_state <= ST_WAIT;
            ST_WAIT: begin
               if (r_ctl.we) begin
                  r_ram_wdata <= w_merged;
                  r_state     <= ST_WR;
               end else begin
                  r_resp_rdata <= w_load;
                  r_resp_valid <= 1'b1;
                  r_state      <= ST_RESP;
               end
            end
            ST_WR: begin
               r_resp_valid <= 1'b1;
               r_state      <= ST_RESP;
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // RAM strobes decode only the state flop, so an async reset drops them at once.
   assign req_ready   = (r_state == ST_IDLE);
   assign ram_ena     = (r_state == ST_RD) || (r_state == ST_WR);
   assign ram_wr_flag = (r_state == ST_WR);
   assign ram_addr    = r_addr;
   assign ram_wdata   = r_ram_wdata;
   assign resp_valid  = r_resp_valid;
   assign resp_rdata  = r_resp_rdata;
   assign resp_err    = r_resp_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, reset/back-to-back sequences, random traffic vs a memory model.
module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_mode = 2'b00;
   logic        req_signed = 1'b0;
   logic [15:0] req_addr = 16'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        ram_ena;
   logic        ram_wr_flag;
   logic [15:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   bit [31:0] mem     [0:16383];
   bit [31:0] ref_mem [0:16383];
   logic        bd_we = 1'b0;
   logic [13:0] bd_idx = 14'h0;
   logic [31:0] bd_data = 32'h0;
   int wr_cnt  = 0;
   int ena_cnt = 0;

   always #5 clk = ~clk;

   data_mem_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_mode    (req_mode),
      .req_signed  (req_signed),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .ram_ena     (ram_ena),
      .ram_wr_flag (ram_wr_flag),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata)
   );

   // Synchronous RAM with a backdoor load port for preloading.
   always @(posedge clk) begin
      if (bd_we) mem[bd_idx] <= bd_data;
      else if (ram_ena) begin
         if (ram_wr_flag) mem[ram_addr[15:2]] <= ram_wdata;
         ram_rdata <= mem[ram_addr[15:2]];
      end
   end

   always @(posedge clk) begin
      if (ram_wr_flag) wr_cnt <= wr_cnt + 1;
      if (ram_ena)     ena_cnt <= ena_cnt + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bd_write(input int idx, input bit [31:0] data);
      @(negedge clk);
      bd_we = 1'b1; bd_idx = 14'(idx); bd_data = data;
      @(negedge clk);
      bd_we = 1'b0;
      ref_mem[idx] = data;
   endtask

   // Reference model: one access applied to ref_mem from size/alignment/endianness rules.
   task automatic model(input bit we, input bit [1:0] mode, input bit sgn, input bit [15:0] addr,
                        input bit [31:0] wd, output bit [31:0] rd, output bit err,
                        output int lat, output int nwr, output int nena);
      int size, idx, sh;
      bit [15:0] a;
      bit [31:0] word, mask, v;
      size = (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : 4;
      err = 1'b0;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
      if (mode == 2'd3 || (addr % size) != 0) err = 1'b1;
`endif
      rd = 32'h0; lat = 1; nwr = 0; nena = 0;
      if (!err) begin
         a    = 16'(addr - addr % size);
         idx  = a / 4;
         sh   = (a % 4) * 8;
         word = ref_mem[idx];
         mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (size * 8)) - 32'h1);
         if (we) begin
            ref_mem[idx] = (word & ~(mask << sh)) | ((wd & mask) << sh);
            nwr  = 1;
            lat  = (size == 4) ? 2 : 4;
            nena = (size == 4) ? 1 : 2;
         end else begin
            v = (word >> sh) & mask;
            if (sgn && size < 4 && v[size*8-1]) v = v | ~mask;
            rd   = v;
            lat  = 3;
            nena = 1;
         end
      end
   endtask

   // Drive one request when ready, then measure latency (cycles after the accept cycle).
   task automatic run_txn(input bit we, input bit [1:0] mode, input bit sgn, input bit [15:0] addr,
                          input bit [31:0] wd, output logic [31:0] rd, output logic err,
                          output int lat, output int nwr, output int nena);
      int wr0, en0;
      @(negedge clk);
      for (int k = 0; k < 10 && !req_ready; k++) @(negedge clk);
      req_we = we; req_mode = mode; req_signed = sgn; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      wr0 = wr_cnt; en0 = ena_cnt;
      @(negedge clk);
      req_valid = 1'b0;
      lat = -1; rd = 32'h0; err = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (resp_valid) begin
            lat = k; rd = resp_rdata; err = resp_err;
            break;
         end
         @(negedge clk);
      end
      nwr  = wr_cnt - wr0;
      nena = ena_cnt - en0;
   endtask

   typedef struct {
      bit        we;
      bit [1:0]  mode;
      bit        sgn;
      bit [15:0] addr;
      bit [31:0] wdata;
      bit [31:0] rdata;
      bit        err;
      int        lat;
      bit [31:0] word;
      int        nwr;
      int        nena;
   } vec_t;

   vec_t vec [16];

   initial begin
      logic [31:0] rd;
      logic        err;
      int          lat, nwr, nena, idx, w0;
      bit [31:0]   m_rd;
      bit          m_err;
      int          m_lat, m_nwr, m_nena;
      bit [15:0]   addr;
      bit [1:0]    mode;
      bit          we, sgn;
      bit [31:0]   wd;
      int          acc_cyc [3];
      int          resp_cyc [3];
      logic [31:0] resp_dat [3];
      bit [15:0]   b_addr [3];
      bit [1:0]    b_mode [3];
      bit          b_sgn [3];
      int          n_acc, n_resp;

      vec[0]  = '{1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, 32'h0,        1'b0, 2, 32'hDEADBEEF, 1, 1};
      vec[1]  = '{1'b0, 2'd2, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0, 3, 32'hDEADBEEF, 0, 1};
      vec[2]  = '{1'b1, 2'd0, 1'b0, 16'h0022, 32'h123456AA, 32'h0,        1'b0, 4, 32'h11AA3344, 1, 2};
      vec[3]  = '{1'b0, 2'd1, 1'b1, 16'h0032, 32'h0,        32'hFFFF80F0, 1'b0, 3, 32'h80F07F01, 0, 1};
      vec[4]  = '{1'b0, 2'd0, 1'b0, 16'h0031, 32'h0,        32'h0000007F, 1'b0, 3, 32'h80F07F01, 0, 1};
      vec[5]  = '{1'b0, 2'd0, 1'b1, 16'h0033, 32'h0,        32'hFFFFFF80, 1'b0, 3, 32'h80F07F01, 0, 1};
      vec[6]  = '{1'b0, 2'd0, 1'b1, 16'h0030, 32'h0,        32'h00000001, 1'b0, 3, 32'h80F07F01, 0, 1};
      vec[7]  = '{1'b0, 2'd1, 1'b0, 16'h0032, 32'h0,        32'h000080F0, 1'b0, 3, 32'h80F07F01, 0, 1};
      vec[8]  = '{1'b0, 2'd1, 1'b1, 16'h0030, 32'h0,        32'h00007F01, 1'b0, 3, 32'h80F07F01, 0, 1};
      vec[9]  = '{1'b0, 2'd2, 1'b1, 16'h0030, 32'h0,        32'h80F07F01, 1'b0, 3, 32'h80F07F01, 0, 1};
      vec[10] = '{1'b1, 2'd1, 1'b0, 16'hFFFE, 32'h0000BEEF, 32'h0,        1'b0, 4, 32'hBEEFC3D4, 1, 2};
      vec[11] = '{1'b0, 2'd2, 1'b0, 16'hFFFC, 32'h0,        32'hBEEFC3D4, 1'b0, 3, 32'hBEEFC3D4, 0, 1};
`ifdef DATA_MEM_MISALIGN_CHECK_EN
      vec[12] = '{1'b0, 2'd2, 1'b0, 16'h0041, 32'h0,        32'h0,        1'b1, 1, 32'hCAFEF00D, 0, 0};
      vec[13] = '{1'b0, 2'd3, 1'b0, 16'h0032, 32'h0,        32'h0,        1'b1, 1, 32'h80F07F01, 0, 0};
      vec[14] = '{1'b1, 2'd1, 1'b0, 16'h0043, 32'h0000ABCD, 32'h0,        1'b1, 1, 32'hCAFEF00D, 0, 0};
`else
      vec[12] = '{1'b0, 2'd2, 1'b0, 16'h0041, 32'h0,        32'hCAFEF00D, 1'b0, 3, 32'hCAFEF00D, 0, 1};
      vec[13] = '{1'b0, 2'd3, 1'b0, 16'h0032, 32'h0,        32'h80F07F01, 1'b0, 3, 32'h80F07F01, 0, 1};
      vec[14] = '{1'b1, 2'd1, 1'b0, 16'h0043, 32'h0000ABCD, 32'h0,        1'b0, 4, 32'hABCDF00D, 1, 2};
`endif
      vec[15] = '{1'b1, 2'd0, 1'b0, 16'h0020, 32'h00000055, 32'h0,        1'b0, 4, 32'h11AA3355, 1, 2};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req_ready",   32'(req_ready),   32'h1);
      check("rst_resp_valid",  32'(resp_valid),  32'h0);
      check("rst_resp_err",    32'(resp_err),    32'h0);
      check("rst_resp_rdata",  resp_rdata,       32'h0);
      check("rst_ram_ena",     32'(ram_ena),     32'h0);
      check("rst_ram_wr_flag", 32'(ram_wr_flag), 32'h0);
      check("rst_ram_addr",    32'(ram_addr),    32'h0);
      check("rst_ram_wdata",   ram_wdata,        32'h0);

      bd_write(16'h0020 >> 2, 32'h11223344);
      bd_write(16'h0030 >> 2, 32'h80F07F01);
      bd_write(16'h0040 >> 2, 32'hCAFEF00D);
      bd_write(16'h0050 >> 2, 32'h55667788);
      bd_write(16383,         32'hA1B2C3D4);
      @(negedge clk);
      rst = 1'b1;

      // Directed vector table
      foreach (vec[i]) begin
         run_txn(vec[i].we, vec[i].mode, vec[i].sgn, vec[i].addr, vec[i].wdata, rd, err, lat, nwr, nena);
         model(vec[i].we, vec[i].mode, vec[i].sgn, vec[i].addr, vec[i].wdata, m_rd, m_err, m_lat, m_nwr, m_nena);
         idx = vec[i].addr >> 2;
         check($sformatf("vec%0d_rdata", i), rd,             vec[i].rdata);
         check($sformatf("vec%0d_err", i),   32'(err),       32'(vec[i].err));
         check($sformatf("vec%0d_lat", i),   32'(lat),       32'(vec[i].lat));
         check($sformatf("vec%0d_word", i),  mem[idx],       vec[i].word);
         check($sformatf("vec%0d_writes", i), 32'(nwr),      32'(vec[i].nwr));
         check($sformatf("vec%0d_ena", i),   32'(nena),      32'(vec[i].nena));
      end

      // Reset during WAIT of a half store aborts it
      @(negedge clk);
      req_we = 1'b1; req_mode = 2'd1; req_signed = 1'b0; req_addr = 16'h0050; req_wdata = 32'h0000_1234;
      req_valid = 1'b1; w0 = wr_cnt;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("wait_abort_no_wr_before", 32'(ram_wr_flag), 32'h0);
      rst = 1'b0;
      #1;
      check("wait_abort_ready_in_rst", 32'(req_ready), 32'h1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("wait_abort_writes", 32'(wr_cnt - w0), 32'h0);
      check("wait_abort_word",   mem[16'h0050 >> 2], 32'h55667788);
      check("wait_abort_ready",  32'(req_ready), 32'h1);

      // Reset during WR drops the write strobe immediately
      req_we = 1'b1; req_mode = 2'd0; req_signed = 1'b0; req_addr = 16'h0051; req_wdata = 32'h0000_0099;
      req_valid = 1'b1; w0 = wr_cnt;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("wr_abort_flag_high", 32'(ram_wr_flag), 32'h1);
      rst = 1'b0;
      #1;
      check("wr_abort_flag_async", 32'(ram_wr_flag), 32'h0);
      check("wr_abort_ena_async",  32'(ram_ena),     32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("wr_abort_writes", 32'(wr_cnt - w0), 32'h0);
      check("wr_abort_word",   mem[16'h0050 >> 2], 32'h55667788);

      // Back-to-back loads with req_valid held high
      b_addr = '{16'h0030, 16'h0032, 16'h0010};
      b_mode = '{2'd2, 2'd1, 2'd2};
      b_sgn  = '{1'b0, 1'b1, 1'b0};
      acc_cyc = '{-100, -100, -100};
      resp_cyc = '{-100, -100, -100};
      resp_dat = '{32'h0, 32'h0, 32'h0};
      n_acc = 0; n_resp = 0;
      for (int i = 0; i < 20; i++) begin
         if (resp_valid) begin
            if (n_resp < 3) begin
               resp_cyc[n_resp] = i;
               resp_dat[n_resp] = resp_rdata;
            end
            n_resp++;
         end
         if (req_ready) begin
            if (n_acc < 3) begin
               req_we = 1'b0; req_mode = b_mode[n_acc]; req_signed = b_sgn[n_acc];
               req_addr = b_addr[n_acc]; req_wdata = $urandom;
               req_valid = 1'b1;
               acc_cyc[n_acc] = i;
               n_acc++;
            end else req_valid = 1'b0;
         end else req_addr = 16'($urandom);
         @(negedge clk);
      end
      req_valid = 1'b0;
      check("b2b_resp_count", 32'(n_resp), 32'd3);
      check("b2b_acc_gap1",   32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
      check("b2b_acc_gap2",   32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
      for (int k = 0; k < 3; k++) begin
         model(1'b0, b_mode[k], b_sgn[k], b_addr[k], 32'h0, m_rd, m_err, m_lat, m_nwr, m_nena);
         check($sformatf("b2b_resp_cyc%0d", k), 32'(resp_cyc[k] - acc_cyc[k]), 32'd3);
         check($sformatf("b2b_rdata%0d", k),    resp_dat[k], m_rd);
      end

      // Random traffic against the reference model
      for (int t = 0; t < 150; t++) begin
         idx  = ($urandom_range(0, 9) == 0) ? 16383 : int'($urandom_range(0, 15));
         addr = 16'(idx * 4 + int'($urandom_range(0, 3)));
         we   = 1'($urandom);
         mode = 2'($urandom);
         sgn  = 1'($urandom);
         wd   = $urandom;
         run_txn(we, mode, sgn, addr, wd, rd, err, lat, nwr, nena);
         model(we, mode, sgn, addr, wd, m_rd, m_err, m_lat, m_nwr, m_nena);
         check($sformatf("rnd%0d_rdata", t),  rd,        m_rd);
         check($sformatf("rnd%0d_err", t),    32'(err),  32'(m_err));
         check($sformatf("rnd%0d_lat", t),    32'(lat),  32'(m_lat));
         check($sformatf("rnd%0d_writes", t), 32'(nwr),  32'(m_nwr));
         check($sformatf("rnd%0d_ena", t),    32'(nena), 32'(m_nena));
         check($sformatf("rnd%0d_word", t),   mem[idx],  ref_mem[idx]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
